multiport_reg_file: RTL and testbench
=====================================

MULTIPORT_REG_FILE -- requirements
Module: multiport_reg_file

Interface
REQ-001 SHALL provide parameter IDX_W, default 4, register index width (2**IDX_W registers).
REQ-002 SHALL provide parameter WIDTH, default 32, data width per register.
REQ-003 SHALL provide parameter NRD, default 3, number of read ports (1..4).
REQ-004 SHALL provide parameter NWR, default 2, number of write ports (1..2).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 rd_en  input  NRD  per-port read request.
REQ-008 rd_addr  input  NRD*IDX_W  packed read indices, port p at [p*IDX_W +: IDX_W].
REQ-009 rd_data  output  NRD*WIDTH  packed registered read data.
REQ-010 rd_valid  output  NRD  one-cycle pulse, rd_data for that port updated.
REQ-011 rd_busy  output  NRD  scoreboard bit of the read register, captured with rd_data.
REQ-012 wr_en  input  NWR  per-port write request.
REQ-013 wr_addr  input  NWR*IDX_W  packed write indices.
REQ-014 wr_data  input  NWR*WIDTH  packed write data.
REQ-015 sb_set  input  1  mark register sb_addr pending (result outstanding).
REQ-016 sb_addr  input  IDX_W  scoreboard set index.
REQ-017 busy  output  2**IDX_W  current scoreboard vector, direct from state flops.

Function
REQ-018 Register 0 SHALL read as zero always; writes and sb_set to index 0 SHALL be ignored.
REQ-019 Writes SHALL commit on the rising edge where wr_en[w]=1; no negedge logic.
REQ-020 Same index on several enabled write ports SHALL commit the highest-numbered port's data only.
REQ-021 Read latency SHALL be 1 cycle: rd_en[p] at edge N -> rd_data/rd_busy/rd_valid[p] valid after edge N.
REQ-022 When rd_en[p]=0, rd_data[p] and rd_busy[p] SHALL hold; rd_valid[p] SHALL be 0.
REQ-023 Each port SHALL operate independently; any number of ports may read the same index in one cycle.
REQ-024 Committed write to index i SHALL clear busy[i] at the same edge.
REQ-025 sb_set SHALL set busy[sb_addr] at the edge; set and write to same index in one cycle -> busy stays 1 (set wins).
REQ-026 rd_busy[p] SHALL reflect busy after that edge's updates when REGFILE_BYPASS_EN is defined, before them otherwise.
REQ-027 Write to an index not being read SHALL NOT disturb any rd_data output.

Reset
REQ-028 rst=1 SHALL asynchronously clear all 2**IDX_W registers (entire array, not a subset), busy, rd_data, rd_busy, rd_valid to 0.
REQ-029 rst asserted mid-operation SHALL discard same-cycle writes, reads, sb_set; first operation accepted at first rising edge after deassertion.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN SHALL select read-during-write behaviour.
REQ-031 Defined: read of index i in same cycle as committed write to i SHALL return the new wr_data (REQ-020 winner); rd_busy per REQ-026.
REQ-032 Undefined: such a read SHALL return the pre-write value; new value visible from the following read.

Verification
REQ-033 Reset, then read all indices on all ports -> rd_data=0, rd_busy=0, rd_valid pulses 1 cycle after each rd_en.
REQ-034 wr_en=2'b11, both wr_addr=5, data 0xAAAA_0001 (port0), 0xBBBB_0002 (port1); next cycle read 5 -> 0xBBBB_0002.
REQ-035 Write 0xDEADBEEF to index 0, then read 0 on ports 0-2 -> all 0x0000_0000; busy[0] stays 0 after sb_set to 0.
REQ-036 Reg 7=0x11; same cycle write 7=0x22 and read 7 -> 0x22 with REGFILE_BYPASS_EN, 0x11 without; next read 0x22 both.
REQ-037 sb_set addr 3 -> busy[3]=1; read 3 -> rd_busy=1; write 3 -> busy[3]=0; sb_set 3 plus write 3 same cycle -> busy[3]=1.
REQ-038 Write regs 1..15 nonzero, assert rst asynchronously between edges -> busy and all outputs 0 immediately; reads after release return 0.

Source files
------------

// File: rtl/multiport_reg_file.sv
// multiport_reg_file: flop-based register file with NRD registered read
// ports, NWR write ports and a per-register busy scoreboard.
// Register 0 is hard-wired to zero and can never be marked busy.
// Optional feature macro: REGFILE_BYPASS_EN. When it is defined, a read in
// the same cycle as a committed write returns the new data and the
// post-update busy bit. When it is undefined, such a read returns the
// pre-write data and busy bit.
// The whole array is cleared by the asynchronous reset, so the storage is
// built from flops rather than block RAM.
module multiport_reg_file #(
    parameter int IDX_W = 4,
    parameter int WIDTH = 32,
    parameter int NRD   = 3,
    parameter int NWR   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRD-1:0]          rd_en,
    input  logic [NRD*IDX_W-1:0]    rd_addr,
    output logic [NRD*WIDTH-1:0]    rd_data,
    output logic [NRD-1:0]          rd_valid,
    output logic [NRD-1:0]          rd_busy,
    input  logic [NWR-1:0]          wr_en,
    input  logic [NWR*IDX_W-1:0]    wr_addr,
    input  logic [NWR*WIDTH-1:0]    wr_data,
    input  logic                    sb_set,
    input  logic [IDX_W-1:0]        sb_addr,
    output logic [(2**IDX_W)-1:0]   busy
);

    localparam int NREG = 2 ** IDX_W;

    // Current and next-state views of the whole array and scoreboard.
    logic [NREG-1:0][WIDTH-1:0] regs_q;
    logic [NREG-1:0][WIDTH-1:0] regs_d;
    logic [NREG-1:0]            busy_q;
    logic [NREG-1:0]            busy_d;

    genvar gi;

    // ------------------------------------------------------------------
    // Storage and scoreboard, one slice per register index
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                // Index 0 has no storage: writes and sb_set are ignored.
                assign regs_q[gi] = '0;
                assign regs_d[gi] = '0;
                assign busy_q[gi] = 1'b0;
                assign busy_d[gi] = 1'b0;
            end else begin : g_live
                logic             hit;
                logic [WIDTH-1:0] data_d;
                logic [WIDTH-1:0] data_q;
                logic             set_hit;
                logic             busy_bit_d;
                logic             busy_bit_q;

                // Find the last enabled write port targeting this index.
                // Ascending scan means the highest-numbered port wins.
                always_comb begin
                    hit    = 1'b0;
                    data_d = data_q;
                    for (int w = 0; w < NWR; w++) begin
                        if (wr_en[w] && (wr_addr[w*IDX_W +: IDX_W] == IDX_W'(gi))) begin
                            hit    = 1'b1;
                            data_d = wr_data[w*WIDTH +: WIDTH];
                        end
                    end
                end

                // A set request beats a clearing write to the same index.
                assign set_hit    = sb_set && (sb_addr == IDX_W'(gi));
                assign busy_bit_d = set_hit ? 1'b1 : (hit ? 1'b0 : busy_bit_q);

                // Register data and busy bit, cleared by asynchronous reset.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        data_q     <= '0;
                        busy_bit_q <= 1'b0;
                    end else begin
                        data_q     <= data_d;
                        busy_bit_q <= busy_bit_d;
                    end
                end

                assign regs_q[gi] = data_q;
                assign regs_d[gi] = data_d;
                assign busy_q[gi] = busy_bit_q;
                assign busy_d[gi] = busy_bit_d;
            end
        end
    endgenerate

    assign busy = busy_q;

    // ------------------------------------------------------------------
    // Read ports: independent, registered, one-cycle latency
    // ------------------------------------------------------------------
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [IDX_W-1:0] addr;
            logic [WIDTH-1:0] src_data;
            logic             src_busy;
            logic [WIDTH-1:0] data_q;
            logic             busy_bit_q;
            logic             valid_q;

            assign addr = rd_addr[gi*IDX_W +: IDX_W];

`ifdef REGFILE_BYPASS_EN
            // Look at the post-update view so same-cycle writes and
            // scoreboard changes are visible immediately.
            assign src_data = regs_d[addr];
            assign src_busy = busy_d[addr];
`else
            // Look at the stored view; same-cycle updates appear on the
            // next read.
            assign src_data = regs_q[addr];
            assign src_busy = busy_q[addr];
`endif

            // Capture data and busy on a request, hold otherwise; valid
            // pulses for exactly the cycle after the request.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q     <= '0;
                    busy_bit_q <= 1'b0;
                    valid_q    <= 1'b0;
                end else begin
                    valid_q <= rd_en[gi];
                    if (rd_en[gi]) begin
                        data_q     <= src_data;
                        busy_bit_q <= src_busy;
                    end
                end
            end

            assign rd_data[gi*WIDTH +: WIDTH] = data_q;
            assign rd_busy[gi]                = busy_bit_q;
            assign rd_valid[gi]               = valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_reg_file.sv
// Directed self-checking bench for multiport_reg_file (default parameters).
module tb_multiport_reg_file;

    localparam int IDX_W = 4;
    localparam int WIDTH = 32;
    localparam int NRD   = 3;
    localparam int NWR   = 2;

    logic                   clk;
    logic                   rst;
    logic [NRD-1:0]         rd_en;
    logic [NRD*IDX_W-1:0]   rd_addr;
    logic [NRD*WIDTH-1:0]   rd_data;
    logic [NRD-1:0]         rd_valid;
    logic [NRD-1:0]         rd_busy;
    logic [NWR-1:0]         wr_en;
    logic [NWR*IDX_W-1:0]   wr_addr;
    logic [NWR*WIDTH-1:0]   wr_data;
    logic                   sb_set;
    logic [IDX_W-1:0]       sb_addr;
    logic [15:0]            busy;

    int n_checks = 0;
    int n_errors = 0;

    multiport_reg_file #(
        .IDX_W(IDX_W), .WIDTH(WIDTH), .NRD(NRD), .NWR(NWR)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set(sb_set), .sb_addr(sb_addr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable to sample.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en = '0; wr_en = '0; sb_set = 1'b0;
    endtask

    logic [31:0] exp_bypass;
    logic        exp_bypass_busy;

    initial begin
        rst = 1'b1; idle();
        rd_addr = '0; wr_addr = '0; wr_data = '0; sb_addr = '0;
        step(); step();
        check("reset_busy", busy, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_busy", rd_busy, 0);
        rst = 1'b0;

        // Read every index on every port after reset.
        for (int i = 0; i < 16; i++) begin
            rd_en = 3'b111;
            rd_addr = {3{i[3:0]}};
            step();
            check($sformatf("zero_read_%0d_data", i), rd_data, 0);
            check($sformatf("zero_read_%0d_valid", i), rd_valid, 3'b111);
            check($sformatf("zero_read_%0d_busy", i), rd_busy, 0);
        end
        idle(); step();
        check("valid_drops", rd_valid, 0);

        // Two ports writing index 5: port 1 wins.
        wr_en = 2'b11; wr_addr = {4'd5, 4'd5};
        wr_data = {32'hBBBB_0002, 32'hAAAA_0001};
        step();
        idle(); rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd5};
        step();
        check("wr_collision_port1_wins", rd_data[31:0], 32'hBBBB_0002);
        check("wr_collision_valid", rd_valid, 3'b001);

        // Writes and sb_set to index 0 are ignored.
        idle(); wr_en = 2'b01; wr_addr = {4'd0, 4'd0}; wr_data = {32'h0, 32'hDEAD_BEEF};
        sb_set = 1'b1; sb_addr = 4'd0;
        step();
        idle(); rd_en = 3'b111; rd_addr = '0;
        step();
        check("reg0_reads_zero", rd_data, 0);
        check("reg0_never_busy", busy, 0);

        // Seed reg 7 while port 1 picks up reg 5.
        idle(); wr_en = 2'b01; wr_addr = {4'd0, 4'd7}; wr_data = {32'h0, 32'h11};
        rd_en = 3'b010; rd_addr = {4'd0, 4'd5, 4'd0};
        step();
        check("port1_reads_5", rd_data[63:32], 32'hBBBB_0002);
        // Overwrite 7 and read it in the same cycle on port 2.
        idle(); wr_en = 2'b10; wr_addr = {4'd7, 4'd0}; wr_data = {32'h22, 32'h0};
        rd_en = 3'b100; rd_addr = {4'd7, 4'd0, 4'd0};
        step();
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'h22;
`else
        exp_bypass = 32'h11;
`endif
        check("rdw_same_cycle", rd_data[95:64], exp_bypass);
        check("port1_undisturbed", rd_data[63:32], 32'hBBBB_0002);
        idle(); rd_en = 3'b100; rd_addr = {4'd7, 4'd0, 4'd0};
        step();
        check("rdw_next_read", rd_data[95:64], 32'h22);

        // Scoreboard on index 3.
        idle(); sb_set = 1'b1; sb_addr = 4'd3;
        step();
        check("sb_set_3", busy, 16'h0008);
        idle(); rd_en = 3'b001; rd_addr = {4'd0, 4'd0, 4'd3};
        step();
        check("rd_busy_3", rd_busy, 3'b001);
        idle();
        step();
        check("rd_busy_hold", rd_busy, 3'b001);
        check("rd_valid_idle", rd_valid, 0);
        // Write 3 clears busy; port 2 reads 3 in the same cycle.
        idle(); wr_en = 2'b10; wr_addr = {4'd3, 4'd0}; wr_data = {32'h33, 32'h0};
        rd_en = 3'b100; rd_addr = {4'd3, 4'd0, 4'd0};
        step();
`ifdef REGFILE_BYPASS_EN
        exp_bypass = 32'h33; exp_bypass_busy = 1'b0;
`else
        exp_bypass = 32'h0;  exp_bypass_busy = 1'b1;
`endif
        check("write_clears_busy", busy, 0);
        check("rdw_busy_3", rd_busy[2], exp_bypass_busy);
        check("rdw_data_3", rd_data[95:64], exp_bypass);
        idle(); sb_set = 1'b1; sb_addr = 4'd3;
        wr_en = 2'b01; wr_addr = {4'd0, 4'd3}; wr_data = {32'h0, 32'h34};
        step();
        check("set_beats_write", busy, 16'h0008);

        // Fill 1..15, mark 3 busy on the last write.
        for (int i = 1; i < 16; i++) begin
            idle(); wr_en = 2'b01; wr_addr = {4'd0, i[3:0]}; wr_data = {32'h0, 32'h100 + i};
            if (i == 15) begin sb_set = 1'b1; sb_addr = 4'd3; end
            step();
        end
        idle(); rd_en = 3'b111; rd_addr = {4'd15, 4'd9, 4'd3};
        step();
        check("prefill_rd", rd_data, {32'h10F, 32'h109, 32'h103});
        check("prefill_rd_busy", rd_busy, 3'b001);
        // Asynchronous reset between edges, with a write pending.
        idle(); wr_en = 2'b01; wr_addr = {4'd0, 4'd5}; wr_data = {32'h0, 32'h55};
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_rd_data", rd_data, 0);
        check("async_rst_rd_busy", rd_busy, 0);
        check("async_rst_rd_valid", rd_valid, 0);
        step();
        rst = 1'b0; idle();
        for (int i = 1; i < 16; i++) begin
            rd_en = 3'b001; rd_addr = {4'd0, 4'd0, i[3:0]};
            step();
            check($sformatf("post_rst_read_%0d", i), rd_data[31:0], 0);
        end
        idle(); step();
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Safety timeout.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
